// File: rtl/design_variables.sv
// Shared widths, letter codes, FSM states and column-to-byte formatting
// for the alignment result packer.
package design_variables;

  localparam int unsigned LETTER_WIDTH    = 2;
  localparam int unsigned SCORE_WIDTH     = 10;
  localparam int unsigned MAX_ALIGN_LEN   = 64;
  localparam int unsigned FRAME_HDR_BYTES = 3;

  localparam int unsigned SYM_W  = LETTER_WIDTH + 1;
  localparam int unsigned COL_W  = 2 * SYM_W;
  localparam int unsigned ADDR_W = $clog2(MAX_ALIGN_LEN);
  localparam int unsigned CNT_W  = $clog2(MAX_ALIGN_LEN + 1);
  localparam int unsigned SEQ_W  = CNT_W + 1;

  localparam logic [LETTER_WIDTH-1:0] LETTER_A = 2'b00;
  localparam logic [LETTER_WIDTH-1:0] LETTER_G = 2'b01;
  localparam logic [LETTER_WIDTH-1:0] LETTER_T = 2'b10;
  localparam logic [LETTER_WIDTH-1:0] LETTER_C = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HEADER,
    ST_PAYLOAD
  } packer_state_t;

  // Gap symbols carry no letter, so letter bits are zeroed on the wire.
  function automatic logic [7:0] col_to_byte(input logic [COL_W-1:0] col);
    logic [SYM_W-1:0] q;
    logic [SYM_W-1:0] d;
    q = col[COL_W-1 -: SYM_W];
    d = col[SYM_W-1:0];
    if (q[SYM_W-1]) q[LETTER_WIDTH-1:0] = '0;
    if (d[SYM_W-1]) d[LETTER_WIDTH-1:0] = '0;
    return 8'({q, d});
  endfunction

endpackage

// File: rtl/align_col_buffer.sv
// Column store for one alignment: synchronous write, combinational read.
module align_col_buffer
  import design_variables::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [COL_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [COL_W-1:0]  rdata
);

  logic [COL_W-1:0] mem [MAX_ALIGN_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alignment_result_packer.sv
// Buffers one streamed alignment and replays it as a framed byte stream:
// score low, score high, length, then one byte per column.
module alignment_result_packer
  import design_variables::*;
#(
  parameter bit REVERSE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SYM_W-1:0]       aln_q_in,
  input  logic [SYM_W-1:0]       aln_d_in,
  input  logic                   aln_valid,
  input  logic                   aln_last,
  input  logic [SCORE_WIDTH-1:0] score_in,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err_overflow
);

  packer_state_t          state;
  logic [CNT_W-1:0]       count;
  logic [ADDR_W-1:0]      rd_ptr;
  logic [SEQ_W-1:0]       seq;
  logic [SCORE_WIDTH-1:0] score_q;

  logic                   buf_we_c;
  logic [ADDR_W-1:0]      buf_waddr_c;
  logic [COL_W-1:0]       buf_rdata_c;
  logic                   advance_c;

  assign buf_we_c    = aln_valid && ((state == ST_IDLE) ||
                       ((state == ST_COLLECT) && (count != CNT_W'(MAX_ALIGN_LEN))));
  assign buf_waddr_c = (state == ST_IDLE) ? '0 : count[ADDR_W-1:0];
  assign advance_c   = !out_valid || out_ready;

  align_col_buffer u_buf (
    .clk   (clk),
    .we    (buf_we_c),
    .waddr (buf_waddr_c),
    .wdata ({aln_q_in, aln_d_in}),
    .raddr (rd_ptr),
    .rdata (buf_rdata_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      count        <= '0;
      rd_ptr       <= '0;
      seq          <= '0;
      score_q      <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aln_valid) begin
            count <= CNT_W'(1);
            busy  <= 1'b1;
            if (aln_last) begin
              score_q <= score_in;
              state   <= ST_HEADER;
            end else begin
              state <= ST_COLLECT;
            end
          end
        end

        ST_COLLECT: begin
          if (aln_valid) begin
            if (count == CNT_W'(MAX_ALIGN_LEN)) err_overflow <= 1'b1;
            else                                count        <= count + CNT_W'(1);
            if (aln_last) begin
              score_q <= score_in;
              state   <= ST_HEADER;
            end
          end
        end

        ST_HEADER, ST_PAYLOAD: begin
          // No capture while draining; anything arriving now is lost.
          if (aln_valid) err_overflow <= 1'b1;
          if (advance_c) begin
            if (out_valid && out_last) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              count     <= '0;
              seq       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              out_valid <= 1'b1;
              seq       <= seq + SEQ_W'(1);
              if (seq < SEQ_W'(FRAME_HDR_BYTES)) begin
                case (seq[1:0])
                  2'd0:    out_data <= score_q[7:0];
                  2'd1:    out_data <= 8'(score_q >> 8);
                  default: begin
                    out_data <= 8'(count);
                    rd_ptr   <= REVERSE ? ADDR_W'(count - CNT_W'(1)) : '0;
                  end
                endcase
              end else begin
                state    <= ST_PAYLOAD;
                out_data <= col_to_byte(buf_rdata_c);
                out_last <= (seq == SEQ_W'(count) + SEQ_W'(FRAME_HDR_BYTES - 1));
                rd_ptr   <= REVERSE ? rd_ptr - ADDR_W'(1) : rd_ptr + ADDR_W'(1);
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alignment_result_packer.md
Name: alignment_result_packer

Overview:
Downstream consumer of the alignment top. It captures the per-column aligned query/database letters and the final score that the top streams out, and buffers one complete alignment. It then emits that alignment as a framed byte stream with valid/ready handshake toward the host/readout interface. The frame is a 3-byte header (score, length) followed by one byte per column, in forward order.

Parameters:
LETTER_WIDTH, 2, bits per nucleotide code; each column symbol is LETTER_WIDTH+1 bits, MSB = gap flag
SCORE_WIDTH, 10, score width; legal range 9..16
MAX_ALIGN_LEN, 64, buffer depth in columns (query 32 + database 32 worst case)
REVERSE, 1, 1 = emit columns last-captured-first (traceback order undone); 0 = capture order

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
aln_q_in  in  LETTER_WIDTH+1  aligned query symbol {gap, letter}
aln_d_in  in  LETTER_WIDTH+1  aligned database symbol {gap, letter}
aln_valid  in  1  column strobe, one column per cycle
aln_last  in  1  final column of alignment; qualified by aln_valid
score_in  in  SCORE_WIDTH  alignment score; sampled with aln_valid&&aln_last
out_data  out  8  frame byte
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts when out_valid&&out_ready
out_last  out  1  final byte of frame
busy  out  1  high in any state other than IDLE
err_overflow  out  1  sticky; column dropped or truncated

Behaviour:
- Reset (async, rst=1): state IDLE, count=0, rd_ptr=0, out_valid=0, out_last=0, out_data=0, busy=0, err_overflow=0. Buffer contents are not cleared.
- FSM states: IDLE, COLLECT, HEADER, PAYLOAD. Transitions:
  - IDLE: on aln_valid, store column at index 0 and set count=1. Go to HEADER if aln_last, else COLLECT.
  - COLLECT: on aln_valid, store at index count and increment count. If count==MAX_ALIGN_LEN, drop the column and set err_overflow. On aln_last, latch score_in and go to HEADER.
  - HEADER: issue three bytes: byte0=score[7:0]; byte1=zero-extended score[SCORE_WIDTH-1:8]; byte2=count (1..MAX_ALIGN_LEN). After the byte2 handshake, go to PAYLOAD.
  - PAYLOAD: issue count bytes, each {2'b00, q_gap, q_letter, d_gap, d_letter}. Letter bits are forced to 0 when the gap bit is set. With REVERSE=1 the read order is count-1 down to 0; otherwise 0 up to count-1. out_last is high with the final byte. Its handshake returns the FSM to IDLE with count=0.
- Latency: out_valid rises on the first clock edge after the capture of the aln_last column. Each subsequent byte is issued on the cycle after the previous handshake, so throughput is 1 byte/cycle with out_ready held high.
- Output registers: out_data/out_valid/out_last are registered. While out_valid && !out_ready, they hold stable.
- Drop during drain: aln_valid in HEADER or PAYLOAD drops the column and sets err_overflow. This includes the cycle of the final handshake, because the FSM accepts only in IDLE/COLLECT.
- err_overflow clears only on rst.
- Ordering: score_in is only sampled with aln_last.
- Reset mid-frame: frame is abandoned; no partial bytes follow reset release.
- Sizing: count width = clog2(MAX_ALIGN_LEN+1); the buffer is a register array.

Decomposition:
- Shared package design_variables holds: LETTER_WIDTH, SCORE_WIDTH, MAX_ALIGN_LEN, letter codes (A=2'b00, G=2'b01, T=2'b10, C=2'b11), the packer_state_t enum, and the FRAME_HDR_BYTES=3 constant.
- One sub-module: align_col_buffer, a MAX_ALIGN_LEN×(2·(LETTER_WIDTH+1)) register array with write port (we, waddr, wdata) and combinational read port.

Test Plan:
- Basic frame: columns in capture order (T/T), (gap/C), (A/A), with last on the third column and score=13, out_ready=1. Required frame: 0x0D, 0x00, 0x03, 0x00, 0x23, 0x12; out_last with 0x12; busy returns low the next cycle.
- Backpressure: same frame, out_ready=0 for 3 cycles while byte1 is pending. out_data must hold 0x00 with out_valid high until out_ready rises, and no byte may be skipped.
- Wide score: single column (A/A) with aln_last and score=10'h2A5. Required frame: 0xA5, 0x02, 0x01, 0x00.
- Truncation: 70 columns sent in one alignment. Length byte must be 0x40, exactly 64 payload bytes, err_overflow=1.
- Drop during drain: aln_valid pulse while in PAYLOAD. err_overflow rises; the current frame is unchanged; the next alignment is captured normally once back in IDLE.
- Reset mid-PAYLOAD: rst pulse after 2 payload bytes. Outputs are 0 immediately; the next alignment produces a complete, correct frame.
